// File: rtl/cache_controller.sv
// Initiator side of the 2-way set-associative data cache: serves CPU loads from the
// cache, fills lines from SRAM on a read miss, and writes stores through to SRAM.
module cache_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      address,
  input  logic [31:0]      wdata,
  input  logic             MEM_R_EN,
  input  logic             MEM_W_EN,
  output logic [31:0]      rdata,
  output logic             ready,
  output logic [16:0]      cache_address,
  output logic [63:0]      cache_write_data,
  output logic             cache_read_en,
  output logic             cache_write_en,
  output logic             cache_invoke_en,
  input  logic [31:0]      cache_read_data,
  input  logic             cache_hit,
  output logic [31:0]      sram_address,
  output logic [31:0]      sram_wdata,
  output logic             sram_read_en,
  output logic             sram_write_en,
  input  logic [63:0]      sram_rdata,
  input  logic             sram_ready,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {
    IDLE,
    R_MISS,
    W_THRU
  } state_t;

  state_t state, next_state;
  logic   hit_inc, miss_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Stores take priority over loads when both enables are raised together.
  always_comb begin
    next_state       = state;
    ready            = 1'b1;
    rdata            = '0;
    cache_read_en    = 1'b0;
    cache_write_en   = 1'b0;
    cache_invoke_en  = 1'b0;
    cache_write_data = '0;
    sram_read_en     = 1'b0;
    sram_write_en    = 1'b0;
    hit_inc          = 1'b0;
    miss_inc         = 1'b0;
    case (state)
      IDLE: begin
        if (MEM_W_EN) begin
          cache_invoke_en = 1'b1;
          ready           = 1'b0;
          next_state      = W_THRU;
        end else if (MEM_R_EN) begin
          if (cache_hit) begin
            cache_read_en = 1'b1;
            rdata         = cache_read_data;
            hit_inc       = 1'b1;
          end else begin
            ready      = 1'b0;
            miss_inc   = 1'b1;
            next_state = R_MISS;
          end
        end
      end
      R_MISS: begin
        sram_read_en = 1'b1;
        ready        = 1'b0;
        if (sram_ready) begin
          cache_write_en   = 1'b1;
          cache_write_data = sram_rdata;
          rdata            = address[2] ? sram_rdata[63:32] : sram_rdata[31:0];
          ready            = 1'b1;
          next_state       = IDLE;
        end
      end
      W_THRU: begin
        sram_write_en = 1'b1;
        ready         = 1'b0;
        if (sram_ready) begin
          ready      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign cache_address = address[18:2];
  assign sram_wdata    = wdata;
  // Line reads are 8-byte aligned; word writes keep the full byte address.
  assign sram_address  = (state == W_THRU || (state == IDLE && MEM_W_EN))
                         ? address : {address[31:3], 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_inc && hit_count != {CNT_W{1'b1}})
        hit_count <= hit_count + CNT_W'(1);
      if (miss_inc && miss_count != {CNT_W{1'b1}})
        miss_count <= miss_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: directed loads/stores drive the DUT while a
// negedge monitor checks every completed request against queued expectations.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic        MEM_R_EN = 1'b0;
  logic        MEM_W_EN = 1'b0;
  logic [31:0] cache_read_data = '0;
  logic        cache_hit = 1'b0;
  logic [63:0] sram_rdata = '0;
  logic        sram_ready = 1'b0;

  logic [31:0] rdata, sram_address, sram_wdata;
  logic        ready, cache_read_en, cache_write_en, cache_invoke_en;
  logic        sram_read_en, sram_write_en;
  logic [16:0] cache_address;
  logic [63:0] cache_write_data;
  logic [15:0] hit_count, miss_count;

  logic [31:0] d2_rdata, d2_sram_address, d2_sram_wdata;
  logic        d2_ready, d2_cache_read_en, d2_cache_write_en, d2_cache_invoke_en;
  logic        d2_sram_read_en, d2_sram_write_en;
  logic [16:0] d2_cache_address;
  logic [63:0] d2_cache_write_data;
  logic [1:0]  d2_hit_count, d2_miss_count;

  int pass_count = 0;
  int total_count = 0;

  typedef struct {
    string       name;
    bit          is_load;
    bit          fill;
    logic [31:0] rdata;
    logic [16:0] caddr;
    logic [63:0] line;
  } exp_t;

  typedef struct {
    int low;
    int invoke;
    int sram;
    int fill;
    int rd;
    int overlap;
    bit sram_ok;
  } obs_t;

  exp_t sb[$];
  obs_t o;

  cache_controller #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
    .cache_address(cache_address), .cache_write_data(cache_write_data),
    .cache_read_en(cache_read_en), .cache_write_en(cache_write_en),
    .cache_invoke_en(cache_invoke_en), .cache_read_data(cache_read_data),
    .cache_hit(cache_hit), .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  cache_controller #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(d2_rdata), .ready(d2_ready),
    .cache_address(d2_cache_address), .cache_write_data(d2_cache_write_data),
    .cache_read_en(d2_cache_read_en), .cache_write_en(d2_cache_write_en),
    .cache_invoke_en(d2_cache_invoke_en), .cache_read_data(cache_read_data),
    .cache_hit(cache_hit), .sram_address(d2_sram_address), .sram_wdata(d2_sram_wdata),
    .sram_read_en(d2_sram_read_en), .sram_write_en(d2_sram_write_en),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .hit_count(d2_hit_count), .miss_count(d2_miss_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic void push_exp(input string name, input bit is_load, input bit fill,
                                   input logic [31:0] rd, input logic [16:0] caddr,
                                   input logic [63:0] line);
    exp_t e;
    e.name = name; e.is_load = is_load; e.fill = fill;
    e.rdata = rd; e.caddr = caddr; e.line = line;
    sb.push_back(e);
  endfunction

  // Monitor: every cycle a request completes, pop one expectation and compare.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (MEM_R_EN || MEM_W_EN) && ready) begin
      if (sb.size() == 0) begin
        total_count++;
        $display("[TB] FAIL unexpected_completion: got ready=1, expected no completion");
      end else begin
        e = sb.pop_front();
        if (e.is_load) checkOutput({e.name, "_rdata"}, rdata, e.rdata);
        checkOutput({e.name, "_fill_strobe"}, cache_write_en, e.fill);
        if (e.fill) begin
          checkOutput({e.name, "_fill_addr"}, cache_address, e.caddr);
          checkOutput({e.name, "_fill_data"}, cache_write_data, e.line);
        end
      end
    end
  end

  // Drives one request (caller is just after a rising edge) and plays the SRAM side:
  // sram_ready is pulsed after lat cycles of an SRAM strobe.
  task automatic applyStimulus(input bit is_load, input logic [31:0] addr,
                               input logic [31:0] wdat, input bit hit,
                               input logic [31:0] hit_data, input int lat,
                               input logic [63:0] line, input logic [31:0] exp_sram_addr,
                               output obs_t ob);
    bit done;
    ob = '{low: 0, invoke: 0, sram: 0, fill: 0, rd: 0, overlap: 0, sram_ok: 1'b1};
    address = addr; wdata = wdat; cache_hit = hit; cache_read_data = hit_data;
    MEM_R_EN = is_load; MEM_W_EN = !is_load;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!ready) ob.low++;
      if (cache_invoke_en) ob.invoke++;
      if (cache_write_en) ob.fill++;
      if (cache_read_en) ob.rd++;
      if (sram_read_en || sram_write_en) begin
        ob.sram++;
        if (sram_address !== exp_sram_addr) ob.sram_ok = 1'b0;
        if (sram_write_en && sram_wdata !== wdat) ob.sram_ok = 1'b0;
      end
      if ((sram_read_en && sram_write_en) ||
          ((sram_read_en || sram_write_en) && (cache_read_en || cache_invoke_en)) ||
          (sram_write_en && cache_write_en))
        ob.overlap++;
      done = ready;
      @(posedge clk); #1;
      if (done) begin
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; cache_hit = 1'b0; sram_ready = 1'b0;
        return;
      end
      if (ob.sram == lat) begin
        sram_ready = 1'b1; sram_rdata = line;
      end else begin
        sram_ready = 1'b0;
      end
    end
    total_count++;
    $display("[TB] FAIL request_timeout: got ready=0 after 40 cycles, expected ready=1");
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; cache_hit = 1'b0; sram_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    checkOutput("reset_ready", ready, 1);
    checkOutput("reset_rdata", rdata, 0);
    checkOutput("reset_strobes", {cache_read_en, cache_write_en, cache_invoke_en,
                                  sram_read_en, sram_write_en}, 0);
    checkOutput("reset_counts", {hit_count, miss_count}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold load miss, odd word of the line
    push_exp("cold_load", 1, 1, 32'h22, 17'h41, 64'h0000_0022_0000_0011);
    applyStimulus(1, 32'h104, 0, 0, 0, 5, 64'h0000_0022_0000_0011, 32'h100, o);
    checkOutput("cold_ready_low", o.low, 6);
    checkOutput("cold_sram_cycles", o.sram, 6);
    checkOutput("cold_fills", o.fill, 1);
    checkOutput("cold_read_en", o.rd, 0);
    checkOutput("cold_sram_addr", o.sram_ok, 1);
    checkOutput("cold_miss_count", miss_count, 1);
    checkOutput("cold_hit_count", hit_count, 0);

    // Same load, now a hit
    push_exp("repeat_hit", 1, 0, 32'h22, 17'h41, 0);
    applyStimulus(1, 32'h104, 0, 1, 32'h22, 0, 0, 32'h100, o);
    checkOutput("hit_ready_low", o.low, 0);
    checkOutput("hit_read_en", o.rd, 1);
    checkOutput("hit_sram_cycles", o.sram, 0);
    checkOutput("hit_count_1", hit_count, 1);

    // Write-through store with invalidate-on-hit
    push_exp("store", 0, 0, 0, 0, 0);
    applyStimulus(0, 32'h104, 32'h55, 1, 32'h22, 2, 0, 32'h104, o);
    checkOutput("store_invoke_cycles", o.invoke, 1);
    checkOutput("store_sram_cycles", o.sram, 3);
    checkOutput("store_ready_low", o.low, 3);
    checkOutput("store_fills", o.fill, 0);
    checkOutput("store_sram_addr_data", o.sram_ok, 1);
    checkOutput("store_overlap", o.overlap, 0);
    checkOutput("store_counts", {hit_count, miss_count}, {16'd1, 16'd1});

    // Even-word miss after the store
    push_exp("even_miss", 1, 1, 32'hAA, 17'h40, 64'h0000_00BB_0000_00AA);
    applyStimulus(1, 32'h100, 0, 0, 0, 3, 64'h0000_00BB_0000_00AA, 32'h100, o);
    checkOutput("even_sram_addr", o.sram_ok, 1);
    checkOutput("even_ready_low", o.low, 4);
    checkOutput("even_overlap", o.overlap, 0);
    checkOutput("even_miss_count", miss_count, 2);

    // Stray sram_ready in IDLE is ignored
    sram_ready = 1'b1;
    @(negedge clk);
    checkOutput("stray_ready", ready, 1);
    checkOutput("stray_strobes", {cache_write_en, sram_read_en, sram_write_en}, 0);
    @(posedge clk); #1;
    sram_ready = 1'b0;
    @(negedge clk);
    checkOutput("stray_still_idle", {sram_read_en, sram_write_en}, 0);
    @(posedge clk); #1;

    // Reset asserted in the second R_MISS cycle
    address = 32'h200; MEM_R_EN = 1'b1; cache_hit = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("pre_reset_sram_read", sram_read_en, 1);
    rst = 1'b1; MEM_R_EN = 1'b0;
    #1;
    checkOutput("rst_sram_read", sram_read_en, 0);
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_counts", {hit_count, miss_count}, 0);
    checkOutput("rst_counts_w2", {d2_hit_count, d2_miss_count}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Five hits: 16-bit counter reaches 5, 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      push_exp("post_reset_hit", 1, 0, 32'h1000 + 32'(i), 17'h41, 0);
      applyStimulus(1, 32'h104, 0, 1, 32'h1000 + 32'(i), 0, 0, 32'h100, o);
      if (i == 0) checkOutput("post_reset_hit_count", hit_count, 1);
    end
    checkOutput("hit_count_5", hit_count, 5);
    checkOutput("hit_count_sat", d2_hit_count, 3);
    checkOutput("miss_count_w2", d2_miss_count, 0);

    @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Initiator side of the 2-way set-associative data cache: sits between the MEM stage and the cache and SRAM controller.
- Drives the cache's read, write (line fill) and invalidate strobes from CPU loads and stores.
- Fetches 64-bit lines from SRAM on a read miss.
- Stores are write-through / no-write-allocate, with invalidate-on-hit.

Parameters:
- CNT_W, 16: width of the saturating hit/miss statistics counters.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- address  in  32  byte address from MEM stage, already rebased (data memory origin = 0)
- wdata  in  32  store data
- MEM_R_EN  in  1  load request
- MEM_W_EN  in  1  store request
- rdata  out  32  load data to CPU
- ready  out  1  request complete; CPU freezes pipeline while 0
- cache_address  out  17  = address[18:2]: tag [16:7], index [6:1], word offset [0]
- cache_write_data  out  64  fill line to cache
- cache_read_en  out  1  read/LRU-update strobe
- cache_write_en  out  1  line fill strobe
- cache_invoke_en  out  1  invalidate-on-hit strobe
- cache_read_data  in  32  cache word for cache_address
- cache_hit  in  1  combinational hit from cache
- sram_address  out  32  {address[31:3],3'b000} for reads; address for writes
- sram_wdata  out  32  = wdata
- sram_read_en  out  1  64-bit line read request
- sram_write_en  out  1  32-bit word write request
- sram_rdata  in  64  line from SRAM: [31:0] = even word, [63:32] = odd word
- sram_ready  in  1  SRAM transaction done, single-cycle pulse
- hit_count  out  CNT_W  load hits, saturating
- miss_count  out  CNT_W  load misses, saturating

Behaviour:
- States: IDLE, R_MISS, W_THRU. State is registered; all outputs are combinational from state and inputs.
- Reset: state = IDLE, counters = 0. With no request: ready = 1, all enables = 0, rdata = 0.
- Reset mid-transaction: immediate return to IDLE. The pending SRAM access is abandoned; the SRAM controller shares rst.
- IDLE, no request: ready = 1, all strobes 0.
- IDLE, MEM_R_EN & cache_hit:
  - cache_read_en = 1, rdata = cache_read_data, ready = 1 in the same cycle (0 added latency).
  - hit_count += 1 at the clock edge. Stay IDLE.
- IDLE, MEM_R_EN & !cache_hit:
  - ready = 0, cache_read_en = 0; miss_count += 1; next state R_MISS.
- R_MISS:
  - sram_read_en = 1 held until sram_ready.
  - On the sram_ready cycle:
    - cache_write_en = 1, cache_write_data = sram_rdata.
    - rdata = address[2] ? sram_rdata[63:32] : sram_rdata[31:0].
    - ready = 1; next state IDLE.
  - Each miss performs exactly one fill. The CPU re-presents the request only after ready.
- IDLE, MEM_W_EN:
  - cache_invoke_en = 1 for this cycle only (the cache ignores it on a miss).
  - ready = 0; next state W_THRU.
  - No cache write; counters unchanged.
- W_THRU:
  - sram_write_en = 1 held until sram_ready.
  - On the sram_ready cycle: ready = 1, next state IDLE.
  - cache_invoke_en = 0 throughout.
- MEM_R_EN & MEM_W_EN together: treated as a store.
- The CPU holds address, wdata and enables stable while ready = 0. Request changes mid-transaction are undefined and are not checked.
- sram_ready arriving in IDLE is ignored.
- Counters saturate at 2^CNT_W-1; no wrap.
- sram_read_en, sram_write_en and the cache strobes are never asserted together, except cache_write_en with sram_read_en on the fill cycle.

Test Plan:
- Cold load: address 0x0000_0104, SRAM returns 0x0000_0022_0000_0011 after 5 cycles.
  - R_MISS entered; ready = 0 for 6 cycles.
  - Fill cycle: cache_write_en = 1 with cache_address = 0x41; rdata = 0x22; miss_count = 1.
- Same load repeated (cache_hit = 1, cache_read_data = 0x22): ready = 1 the same cycle, cache_read_en = 1, no SRAM strobe, hit_count = 1.
- Store 0x55 to 0x104 with cache_hit = 1:
  - cache_invoke_en high for exactly 1 cycle.
  - sram_write_en high until sram_ready (3 cycles); sram_address = 0x104, sram_wdata = 0x55; cache_write_en never 1.
- Load of 0x100 after the store, cache_hit = 0: miss path, sram_address = 0x100, rdata = sram_rdata[31:0].
- rst asserted in R_MISS cycle 2:
  - Outputs drop immediately: sram_read_en = 0, ready = 1, counters = 0.
  - After release, a hit completes normally.
- CNT_W = 2, 5 hits: hit_count = 3 and holds.
